noise_mix_sequencer: RTL and testbench

//  Sequences one CODEC sample frame: reads L/R from the audio CODEC FIFO, steps the

---
 rtl/audio_pkg.sv | 18 +
 rtl/noise_mix_sat.sv | 36 +++
 rtl/noise_mix_sequencer.sv | 124 ++++++++++++
 tb/tb_noise_mix_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the CODEC noise-mix datapath.
package audio_pkg;

    localparam int SAMPLE_W = 24;

    localparam logic [SAMPLE_W-1:0] SAT_MAX = 24'h7FFFFF;
    localparam logic [SAMPLE_W-1:0] SAT_MIN = 24'h800000;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        STEP,
        MIX,
        WAIT_WR,
        WRITE
    } state_t;

endpackage

// File: rtl/noise_mix_sat.sv
// Combinational mixer: adds the arithmetically shifted noise to one sample and
// clamps the result to the signed sample range.
module noise_mix_sat
    import audio_pkg::*;
#(
    parameter int W = SAMPLE_W
) (
    input  logic [W-1:0] sample,
    input  logic [W-1:0] noise,
    input  logic [1:0]   shift,
    input  logic         en,
    output logic [W-1:0] mixed,
    output logic         clamped
);

    localparam logic [W-1:0] MAX_VAL = (W == SAMPLE_W) ? W'(SAT_MAX) : {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_VAL = (W == SAMPLE_W) ? W'(SAT_MIN) : {1'b1, {(W-1){1'b0}}};

    logic signed [W-1:0] scaled;
    logic        [W:0]   sum;

    // One guard bit is enough: overflow shows up as the two top sum bits disagreeing.
    always_comb begin
        scaled  = $signed(noise) >>> shift;
        sum     = {sample[W-1], sample} + (en ? {scaled[W-1], scaled} : '0);
        clamped = (sum[W] != sum[W-1]);
        if (!clamped) begin
            mixed = sum[W-1:0];
        end else if (sum[W]) begin
            mixed = MIN_VAL;
        end else begin
            mixed = MAX_VAL;
        end
    end

endmodule

// File: rtl/noise_mix_sequencer.sv
// Per-frame sequencer: pop a CODEC frame, optionally step the noise generator,
// mix with saturation, and push the result back under write backpressure.
module noise_mix_sequencer
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = audio_pkg::SAMPLE_W,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                read_ready,
    input  logic                write_ready,
    input  logic [SAMPLE_W-1:0] readdata_left,
    input  logic [SAMPLE_W-1:0] readdata_right,
    input  logic [SAMPLE_W-1:0] noise_q,
    input  logic                noise_on,
    input  logic [1:0]          noise_shift,
    input  logic                clr_sat,
    output logic                read,
    output logic                write,
    output logic [SAMPLE_W-1:0] writedata_left,
    output logic [SAMPLE_W-1:0] writedata_right,
    output logic                noise_en,
    output logic                sat_flag,
    output logic [CNT_W-1:0]    frame_cnt
);

    state_t state;
    state_t next_state;

    logic [SAMPLE_W-1:0] left_q;
    logic [SAMPLE_W-1:0] right_q;
    logic                noise_on_q;
    logic [1:0]          shift_q;

    logic [SAMPLE_W-1:0] mix_left;
    logic [SAMPLE_W-1:0] mix_right;
    logic                clamp_left;
    logic                clamp_right;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (read_ready) next_state = READ;
            READ:    next_state = noise_on ? STEP : MIX;
            STEP:    next_state = MIX;
            MIX:     next_state = WAIT_WR;
            WAIT_WR: if (write_ready) next_state = WRITE;
            WRITE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        read     = (state == READ);
        write    = (state == WRITE);
        noise_en = (state == STEP);
    end

    // Frame controls are captured once so later input changes cannot disturb it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            left_q     <= '0;
            right_q    <= '0;
            noise_on_q <= 1'b0;
            shift_q    <= '0;
        end else if (state == READ) begin
            left_q     <= readdata_left;
            right_q    <= readdata_right;
            noise_on_q <= noise_on;
            shift_q    <= noise_shift;
        end
    end

    noise_mix_sat #(.W(SAMPLE_W)) u_mix_left (
        .sample  (left_q),
        .noise   (noise_q),
        .shift   (shift_q),
        .en      (noise_on_q),
        .mixed   (mix_left),
        .clamped (clamp_left)
    );

    noise_mix_sat #(.W(SAMPLE_W)) u_mix_right (
        .sample  (right_q),
        .noise   (noise_q),
        .shift   (shift_q),
        .en      (noise_on_q),
        .mixed   (mix_right),
        .clamped (clamp_right)
    );

    // A clamp in MIX outranks a simultaneous clear so no saturation event is lost.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            writedata_left  <= '0;
            writedata_right <= '0;
            sat_flag        <= 1'b0;
            frame_cnt       <= '0;
        end else begin
            if (state == MIX) begin
                writedata_left  <= mix_left;
                writedata_right <= mix_right;
            end
            if (state == MIX && (clamp_left || clamp_right)) begin
                sat_flag <= 1'b1;
            end else if (clr_sat) begin
                sat_flag <= 1'b0;
            end
            if (state == WRITE) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_noise_mix_sequencer.sv
// Randomised and directed bench for noise_mix_sequencer against a sample-level
// reference model; the counter is narrowed so its wrap is reachable.
module tb_noise_mix_sequencer;

    localparam int W     = 24;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             read_ready;
    logic             write_ready;
    logic [W-1:0]     readdata_left;
    logic [W-1:0]     readdata_right;
    logic [W-1:0]     noise_q;
    logic             noise_on;
    logic [1:0]       noise_shift;
    logic             clr_sat;
    logic             read;
    logic             write;
    logic [W-1:0]     writedata_left;
    logic [W-1:0]     writedata_right;
    logic             noise_en;
    logic             sat_flag;
    logic [CNT_W-1:0] frame_cnt;

    logic [W-1:0]     next_noise;
    int               compared = 0;
    int               mismatched = 0;
    int               frames_issued = 0;
    logic             sat_model = 1'b0;

    always #5 clk = ~clk;

    // Stand-in for the external noise generator: Q advances once per enable pulse.
    always @(posedge clk) begin
        if (noise_en) noise_q <= next_noise;
    end

    noise_mix_sequencer #(.SAMPLE_W(W), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .read_ready      (read_ready),
        .write_ready     (write_ready),
        .readdata_left   (readdata_left),
        .readdata_right  (readdata_right),
        .noise_q         (noise_q),
        .noise_on        (noise_on),
        .noise_shift     (noise_shift),
        .clr_sat         (clr_sat),
        .read            (read),
        .write           (write),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right),
        .noise_en        (noise_en),
        .sat_flag        (sat_flag),
        .frame_cnt       (frame_cnt)
    );

    // Reference: signed integer sum with floor-divided noise, clamped to 24-bit range.
    function automatic logic [23:0] ref_mix(input logic [23:0] s, input logic [23:0] nz,
                                            input logic on, input logic [1:0] sh,
                                            output logic clamp);
        int acc, n, d, q;
        acc = $signed(s);
        if (on) begin
            n = $signed(nz);
            d = 1 << sh;
            q = n / d;
            if ((n % d) != 0 && n < 0) q = q - 1;
            acc = acc + q;
        end
        clamp = 1'b0;
        if (acc > 8388607) begin
            acc   = 8388607;
            clamp = 1'b1;
        end else if (acc < -8388608) begin
            acc   = -8388608;
            clamp = 1'b1;
        end
        return acc[23:0];
    endfunction

    // Drives one frame from IDLE and reports what was observed; timing is relative to the read cycle.
    task automatic do_frame(input logic [23:0] l, input logic [23:0] r, input logic on,
                            input logic [1:0] sh, input logic [23:0] nz, input int wr_hold,
                            output int t_write, output int n_reads, output int n_writes,
                            output int n_noise, output int t_noise,
                            output logic [23:0] out_l, output logic [23:0] out_r,
                            output logic sat_seen, output logic timeout);
        int t_read, write_abs;
        readdata_left  = l;
        readdata_right = r;
        noise_on       = on;
        noise_shift    = sh;
        next_noise     = nz;
        read_ready     = 1'b1;
        write_ready    = (wr_hold == 0);
        t_read = -1; write_abs = -1; t_write = -1; t_noise = -1;
        n_reads = 0; n_writes = 0; n_noise = 0;
        out_l = '0; out_r = '0; sat_seen = 1'b0; timeout = 1'b1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (sat_flag) sat_seen = 1'b1;
            if (read) begin
                n_reads++;
                if (t_read < 0) t_read = c;
            end
            if (t_read >= 0 && c == t_read + 1) begin
                readdata_left  = 24'($urandom);
                readdata_right = 24'($urandom);
                noise_on       = 1'($urandom);
                noise_shift    = 2'($urandom);
            end
            if (noise_en) begin
                n_noise++;
                t_noise = c - t_read;
            end
            if (write) n_writes++;
            if (write_abs >= 0 && c > write_abs) begin
                timeout = 1'b0;
                break;
            end
            if (write && write_abs < 0) begin
                write_abs  = c;
                t_write    = c - t_read;
                out_l      = writedata_left;
                out_r      = writedata_right;
                read_ready = 1'b0;
            end
            if (t_read >= 0 && c - t_read >= wr_hold) write_ready = 1'b1;
        end
        read_ready  = 1'b0;
        write_ready = 1'b0;
        if (!timeout) frames_issued++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; read_ready = 1'b1; write_ready = 1'b0; clr_sat = 1'b0;
        readdata_left = 24'h123456; readdata_right = 24'h654321;
        noise_on = 1'b1; noise_shift = 2'd0; noise_q = '0; next_noise = '0;
        repeat (3) @(negedge clk);
        compared += 6;
        if (read !== 1'b0)     begin mismatched++; $display("[TB] FAIL reset_read: got %b expected 0", read); end
        if (write !== 1'b0)    begin mismatched++; $display("[TB] FAIL reset_write: got %b expected 0", write); end
        if (noise_en !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_noise_en: got %b expected 0", noise_en); end
        if (writedata_left !== 24'h0 || writedata_right !== 24'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_writedata: got %h/%h expected 0/0", writedata_left, writedata_right);
        end
        if (frame_cnt !== '0)  begin mismatched++; $display("[TB] FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
        if (sat_flag !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_sat_flag: got %b expected 0", sat_flag); end
        read_ready = 1'b0;
        reset_n    = 1'b1;
        @(negedge clk);
        frames_issued = 0;
        sat_model     = 1'b0;
    endtask

    task automatic test_bypass();
        int tw, nr, nw, nn, tn;
        logic [23:0] ol, orr;
        logic ss, to;
        do_frame(24'h000100, 24'hFFFF00, 1'b0, 2'd0, 24'h0ABCDE, 0, tw, nr, nw, nn, tn, ol, orr, ss, to);
        compared += 5;
        if (to !== 1'b0) begin mismatched++; $display("[TB] FAIL bypass_timeout: got timeout expected write"); end
        if (tw != 3) begin mismatched++; $display("[TB] FAIL bypass_latency: got %0d expected 3", tw); end
        if (nr != 1 || nw != 1) begin mismatched++; $display("[TB] FAIL bypass_strobes: got reads=%0d writes=%0d expected 1/1", nr, nw); end
        if (nn != 0) begin mismatched++; $display("[TB] FAIL bypass_noise_en: got %0d pulses expected 0", nn); end
        if (ol !== 24'h000100 || orr !== 24'hFFFF00) begin
            mismatched++;
            $display("[TB] FAIL bypass_data: got %h/%h expected 000100/ffff00", ol, orr);
        end
    endtask

    task automatic test_noise();
        int tw, nr, nw, nn, tn;
        logic [23:0] ol, orr;
        logic ss, to;
        do_frame(24'h000100, 24'h000000, 1'b1, 2'd0, 24'h001800, 0, tw, nr, nw, nn, tn, ol, orr, ss, to);
        compared += 4;
        if (to !== 1'b0 || tw != 4) begin mismatched++; $display("[TB] FAIL noise_latency: got %0d expected 4", tw); end
        if (nn != 1 || tn != 1) begin mismatched++; $display("[TB] FAIL noise_step: got pulses=%0d at=%0d expected 1 at 1", nn, tn); end
        if (ol !== 24'h001900 || orr !== 24'h001800) begin
            mismatched++;
            $display("[TB] FAIL noise_data: got %h/%h expected 001900/001800", ol, orr);
        end
        if (frame_cnt !== CNT_W'(frames_issued)) begin
            mismatched++;
            $display("[TB] FAIL noise_frame_cnt: got %0d expected %0d", frame_cnt, frames_issued % (1 << CNT_W));
        end
    endtask

    task automatic test_saturation();
        int tw, nr, nw, nn, tn;
        logic [23:0] ol, orr;
        logic ss, to;
        do_frame(24'h7FFFF0, 24'h000000, 1'b1, 2'd0, 24'h001800, 0, tw, nr, nw, nn, tn, ol, orr, ss, to);
        compared += 2;
        if (ol !== 24'h7FFFFF || orr !== 24'h001800) begin
            mismatched++;
            $display("[TB] FAIL sat_pos_data: got %h/%h expected 7fffff/001800", ol, orr);
        end
        if (sat_flag !== 1'b1) begin mismatched++; $display("[TB] FAIL sat_pos_flag: got %b expected 1", sat_flag); end

        do_frame(24'h000000, 24'h800010, 1'b1, 2'd0, 24'hFFE000, 0, tw, nr, nw, nn, tn, ol, orr, ss, to);
        compared += 1;
        if (ol !== 24'hFFE000 || orr !== 24'h800000) begin
            mismatched++;
            $display("[TB] FAIL sat_neg_data: got %h/%h expected ffe000/800000", ol, orr);
        end

        do_frame(24'h000100, 24'h000000, 1'b1, 2'd2, 24'hFFE000, 0, tw, nr, nw, nn, tn, ol, orr, ss, to);
        compared += 2;
        if (ol !== 24'hFFF900 || orr !== 24'hFFF800) begin
            mismatched++;
            $display("[TB] FAIL shift2_data: got %h/%h expected fff900/fff800", ol, orr);
        end
        if (sat_flag !== 1'b1) begin mismatched++; $display("[TB] FAIL sat_sticky: got %b expected 1", sat_flag); end

        clr_sat = 1'b1;
        @(negedge clk);
        clr_sat = 1'b0;
        compared += 1;
        if (sat_flag !== 1'b0) begin mismatched++; $display("[TB] FAIL sat_clear: got %b expected 0", sat_flag); end

        // Clear held through a clamping MIX: the flag must still show up for one cycle.
        clr_sat = 1'b1;
        do_frame(24'h7FFFFF, 24'h000000, 1'b1, 2'd0, 24'h000001, 0, tw, nr, nw, nn, tn, ol, orr, ss, to);
        compared += 2;
        if (ss !== 1'b1) begin mismatched++; $display("[TB] FAIL sat_set_wins: got seen=%b expected 1", ss); end
        if (sat_flag !== 1'b0) begin mismatched++; $display("[TB] FAIL sat_clear_after: got %b expected 0", sat_flag); end
        clr_sat   = 1'b0;
        sat_model = 1'b0;
    endtask

    task automatic test_backpressure();
        int tw, nr, nw, nn, tn;
        logic [23:0] ol, orr;
        logic ss, to;
        logic        clamp;
        logic [23:0] exp_l;
        exp_l = ref_mix(24'h012345, 24'h000777, 1'b1, 2'd1, clamp);
        do_frame(24'h012345, 24'h000000, 1'b1, 2'd1, 24'h000777, 14, tw, nr, nw, nn, tn, ol, orr, ss, to);
        compared += 3;
        if (to !== 1'b0 || tw != 15) begin mismatched++; $display("[TB] FAIL bp_latency: got %0d expected 15", tw); end
        if (nr != 1 || nw != 1) begin mismatched++; $display("[TB] FAIL bp_strobes: got reads=%0d writes=%0d expected 1/1", nr, nw); end
        if (ol !== exp_l) begin mismatched++; $display("[TB] FAIL bp_data: got %h expected %h", ol, exp_l); end
    endtask

    task automatic test_reset_mid_frame();
        int   wr_count;
        logic hit;
        hit = 1'b0;
        readdata_left = 24'h111111; readdata_right = 24'h222222;
        noise_on = 1'b1; noise_shift = 2'd0; next_noise = 24'h000010;
        read_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (read) read_ready = 1'b0;
            if (noise_en) begin
                hit = 1'b1;
                break;
            end
        end
        compared += 1;
        if (!hit) begin mismatched++; $display("[TB] FAIL midreset_step: got no noise_en expected pulse"); end
        reset_n = 1'b0;
        @(negedge clk);
        compared += 3;
        if (read !== 1'b0 || write !== 1'b0 || noise_en !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL midreset_strobes: got r=%b w=%b n=%b expected 0/0/0", read, write, noise_en);
        end
        if (writedata_left !== 24'h0 || writedata_right !== 24'h0) begin
            mismatched++;
            $display("[TB] FAIL midreset_data: got %h/%h expected 0/0", writedata_left, writedata_right);
        end
        if (frame_cnt !== '0) begin mismatched++; $display("[TB] FAIL midreset_cnt: got %0d expected 0", frame_cnt); end
        reset_n  = 1'b1;
        write_ready = 1'b1;
        wr_count = 0;
        repeat (8) begin
            @(negedge clk);
            if (write) wr_count++;
        end
        write_ready = 1'b0;
        compared += 1;
        if (wr_count != 0) begin mismatched++; $display("[TB] FAIL midreset_no_write: got %0d writes expected 0", wr_count); end
        frames_issued = 0;
        sat_model     = 1'b0;
    endtask

    task automatic test_random();
        int tw, nr, nw, nn, tn, hold, exp_tw;
        logic [23:0] l, r, nz, ol, orr, el, er;
        logic ss, to, on, cl, cr;
        logic [1:0] sh;
        for (int i = 0; i < 24; i++) begin
            l    = 24'($urandom);
            r    = 24'($urandom);
            nz   = 24'($urandom);
            on   = 1'($urandom);
            sh   = 2'($urandom);
            hold = $urandom_range(0, 6);
            el = ref_mix(l, nz, on, sh, cl);
            er = ref_mix(r, nz, on, sh, cr);
            exp_tw = (on ? 4 : 3);
            if (hold + 1 > exp_tw) exp_tw = hold + 1;
            do_frame(l, r, on, sh, nz, hold, tw, nr, nw, nn, tn, ol, orr, ss, to);
            sat_model = sat_model | cl | cr;
            compared += 5;
            if (to !== 1'b0 || tw != exp_tw) begin
                mismatched++;
                $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", i, tw, exp_tw);
            end
            if (nr != 1 || nw != 1 || nn != (on ? 1 : 0)) begin
                mismatched++;
                $display("[TB] FAIL rand_strobes[%0d]: got r=%0d w=%0d n=%0d expected 1/1/%0d", i, nr, nw, nn, on);
            end
            if (ol !== el || orr !== er) begin
                mismatched++;
                $display("[TB] FAIL rand_data[%0d]: got %h/%h expected %h/%h", i, ol, orr, el, er);
            end
            if (sat_flag !== sat_model) begin
                mismatched++;
                $display("[TB] FAIL rand_sat[%0d]: got %b expected %b", i, sat_flag, sat_model);
            end
            if (frame_cnt !== CNT_W'(frames_issued)) begin
                mismatched++;
                $display("[TB] FAIL rand_cnt[%0d]: got %0d expected %0d", i, frame_cnt, frames_issued % (1 << CNT_W));
            end
            if ($urandom_range(0, 3) == 0) begin
                clr_sat = 1'b1;
                @(negedge clk);
                clr_sat   = 1'b0;
                sat_model = 1'b0;
            end
        end
    endtask

    task automatic test_wrap();
        int tw, nr, nw, nn, tn;
        logic [23:0] ol, orr;
        logic ss, to;
        while (frames_issued % (1 << CNT_W) != (1 << CNT_W) - 1) begin
            do_frame(24'h000001, 24'h000002, 1'b0, 2'd0, 24'h0, 0, tw, nr, nw, nn, tn, ol, orr, ss, to);
            if (to) break;
        end
        compared += 1;
        if (frame_cnt !== {CNT_W{1'b1}}) begin
            mismatched++;
            $display("[TB] FAIL wrap_top: got %0d expected %0d", frame_cnt, (1 << CNT_W) - 1);
        end
        do_frame(24'h000001, 24'h000002, 1'b0, 2'd0, 24'h0, 0, tw, nr, nw, nn, tn, ol, orr, ss, to);
        compared += 1;
        if (to !== 1'b0 || frame_cnt !== '0) begin
            mismatched++;
            $display("[TB] FAIL wrap_zero: got %0d expected 0", frame_cnt);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_bypass();
        test_noise();
        test_saturation();
        test_backpressure();
        test_reset_mid_frame();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
